// File: rtl/vend_pkg.sv
// Shared types and default coin table for the vending credit controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } vend_state_e;

    localparam int          DEF_NUM_COINS  = 3;
    localparam int          DEF_CREDIT_W   = 8;
    localparam logic [23:0] DEF_COIN_VALS  = {8'd25, 8'd10, 8'd5};
    localparam int          DEF_MAX_CREDIT = 100;
    localparam int          DEF_DB_STAGES  = 3;

endpackage

// File: rtl/vend_credit_ctrl_debounce.sv
// Per-coin debouncer: level is high only after DB_STAGES consecutive high samples.
module coin_debounce #(
    parameter int DB_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    logic [DB_STAGES-1:0] sr;
    logic                 db_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            db_prev <= 1'b0;
        end else begin
            sr      <= {sr[DB_STAGES-2:0], raw};
            db_prev <= db;
        end
    end

    assign db   = &sr;
    assign rise = db & ~db_prev;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin-credit controller: debounced value-weighted credit, vend on price match,
// change/refund returned through a valid/ack handshake.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int                            NUM_COINS  = DEF_NUM_COINS,
    parameter int                            CREDIT_W   = DEF_CREDIT_W,
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALS  = DEF_COIN_VALS,
    parameter int                            MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int                            DB_STAGES  = DEF_DB_STAGES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_COINS-1:0] coin_raw,
    input  logic                 vend_req,
    input  logic                 cancel,
    input  logic [CREDIT_W-1:0]  price,
    input  logic                 change_ack,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 vend,
    output logic                 insufficient,
    output logic                 coin_reject,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amt,
    output logic [1:0]           state
);

    vend_state_e          cur_state, nxt_state;
    logic [CREDIT_W-1:0]  credit_r, credit_nxt;
    logic [CREDIT_W-1:0]  change_r, change_nxt;
    logic                 insuf_nxt, reject_nxt;

    logic [NUM_COINS-1:0] coin_db, coin_edge, lowest, extra;
    logic [CREDIT_W-1:0]  coin_val;
    logic [CREDIT_W:0]    sum;
    logic                 has_coin, fits;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_db
            coin_debounce #(.DB_STAGES(DB_STAGES)) u_db (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (coin_raw[gi]),
                .db   (coin_db[gi]),
                .rise (coin_edge[gi])
            );
        end
    endgenerate

    // Lowest-index edge is the candidate; any other simultaneous edge is rejected.
    assign lowest   = coin_edge & (~coin_edge + NUM_COINS'(1));
    assign extra    = coin_edge & ~lowest;
    assign has_coin = |coin_edge;

    always_comb begin
        coin_val = '0;
        for (int i = 0; i < NUM_COINS; i++)
            if (lowest[i]) coin_val = COIN_VALS[i*CREDIT_W +: CREDIT_W];
    end

    // One extra bit so an over-limit sum can never wrap into an accepted value.
    assign sum  = {1'b0, credit_r} + {1'b0, coin_val};
    assign fits = sum <= (CREDIT_W+1)'(MAX_CREDIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= IDLE;
            credit_r     <= '0;
            change_r     <= '0;
            vend         <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            credit_r     <= credit_nxt;
            change_r     <= change_nxt;
            vend         <= (nxt_state == DISPENSE);
            insufficient <= insuf_nxt;
            coin_reject  <= reject_nxt;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        credit_nxt = credit_r;
        change_nxt = change_r;
        insuf_nxt  = 1'b0;
        reject_nxt = |extra;
        case (cur_state)
            IDLE: begin
                if (has_coin) begin
                    if (fits) begin
                        credit_nxt = sum[CREDIT_W-1:0];
                        nxt_state  = ACCUM;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (cancel) begin
                    change_nxt = credit_r;
                    credit_nxt = '0;
                    nxt_state  = REFUND;
                    if (has_coin) reject_nxt = 1'b1;
                end else if (vend_req) begin
                    if (credit_r >= price) begin
                        change_nxt = credit_r - price;
                        credit_nxt = '0;
                        nxt_state  = DISPENSE;
                    end else begin
                        insuf_nxt = 1'b1;
                    end
                    if (has_coin) reject_nxt = 1'b1;
                end else if (has_coin) begin
                    if (fits) credit_nxt = sum[CREDIT_W-1:0];
                    else      reject_nxt = 1'b1;
                end
            end
            DISPENSE: begin
                nxt_state = (change_r != '0) ? REFUND : IDLE;
                if (has_coin) reject_nxt = 1'b1;
            end
            REFUND: begin
                if (change_ack) begin
                    change_nxt = '0;
                    nxt_state  = IDLE;
                end
                if (has_coin) reject_nxt = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Pending change is held internally through DISPENSE but only exposed in REFUND.
    always_comb begin
        state        = cur_state;
        credit       = credit_r;
        change_valid = (cur_state == REFUND);
        change_amt   = change_valid ? change_r : '0;
    end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl: vector table plus hand-written corner sequences.
module tb_vend_credit_ctrl;
    import vend_pkg::*;

    // coin 0 = 25, coin 1 = 10, coin 2 = 5
    localparam logic [23:0] VALS = {8'd5, 8'd10, 8'd25};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] coin_raw = '0;
    logic       vend_req = 1'b0, cancel = 1'b0, change_ack = 1'b0;
    logic [7:0] price = '0;
    logic [7:0] credit, change_amt;
    logic       vend, insufficient, coin_reject, change_valid;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    vend_credit_ctrl #(
        .NUM_COINS(3), .CREDIT_W(8), .COIN_VALS(VALS), .MAX_CREDIT(100), .DB_STAGES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_raw(coin_raw), .vend_req(vend_req),
        .cancel(cancel), .price(price), .change_ack(change_ack), .credit(credit),
        .vend(vend), .insufficient(insufficient), .coin_reject(coin_reject),
        .change_valid(change_valid), .change_amt(change_amt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] coin;
        logic       vreq, canc;
        logic [7:0] price;
        logic       ack;
        int         n;
        logic [7:0] e_credit;
        logic [1:0] e_state;
        logic       e_vend, e_insuf, e_rej, e_cv;
        logic [7:0] e_amt;
    } vec_t;

    vec_t vecs[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] c, input logic vr, input logic cn, input logic [7:0] p,
                       input logic a, input int n, input logic [7:0] cr, input logic [1:0] st,
                       input logic v, input logic i, input logic r, input logic cv,
                       input logic [7:0] amt);
        vec_t t;
        t.coin = c; t.vreq = vr; t.canc = cn; t.price = p; t.ack = a; t.n = n;
        t.e_credit = cr; t.e_state = st; t.e_vend = v; t.e_insuf = i; t.e_rej = r;
        t.e_cv = cv; t.e_amt = amt;
        vecs.push_back(t);
    endtask

    initial begin
        // Purchase with change: 25+25+10 = 60, price 50
        add(3'b001,0,0, 0,0,4,  25,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  25,1,0,0,0,0, 0);
        add(3'b001,0,0, 0,0,4,  50,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  50,1,0,0,0,0, 0);
        add(3'b010,0,0, 0,0,4,  60,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  60,1,0,0,0,0, 0);
        add(3'b000,1,0,50,0,1,   0,2,1,0,0,0, 0);
        add(3'b000,1,0,50,0,1,   0,3,0,0,0,1,10);
        add(3'b000,1,0,50,0,4,   0,3,0,0,0,1,10);
        add(3'b000,1,0,50,1,1,   0,0,0,0,0,0, 0);
        add(3'b000,1,0,50,0,2,   0,0,0,0,0,0, 0);
        // Insufficient credit, repeated; coin with vend_req rejected; cancel beats vend_req
        add(3'b001,0,0,50,0,4,  25,1,0,0,0,0, 0);
        add(3'b000,0,0,50,0,2,  25,1,0,0,0,0, 0);
        add(3'b100,0,0,50,0,4,  30,1,0,0,0,0, 0);
        add(3'b000,0,0,50,0,2,  30,1,0,0,0,0, 0);
        add(3'b000,1,0,50,0,1,  30,1,0,1,0,0, 0);
        add(3'b000,1,0,50,0,1,  30,1,0,1,0,0, 0);
        add(3'b010,1,0,50,0,4,  30,1,0,1,1,0, 0);
        add(3'b000,1,0,50,0,1,  30,1,0,1,0,0, 0);
        add(3'b000,1,1,50,0,1,   0,3,0,0,0,1,30);
        add(3'b010,0,0, 0,0,4,   0,3,0,0,1,1,30);
        add(3'b000,0,0, 0,1,1,   0,0,0,0,0,0, 0);
        // Saturation: reach 95, 10 rejected, 5 lands exactly on 100
        add(3'b001,0,0, 0,0,4,  25,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  25,1,0,0,0,0, 0);
        add(3'b001,0,0, 0,0,4,  50,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  50,1,0,0,0,0, 0);
        add(3'b001,0,0, 0,0,4,  75,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  75,1,0,0,0,0, 0);
        add(3'b010,0,0, 0,0,4,  85,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  85,1,0,0,0,0, 0);
        add(3'b010,0,0, 0,0,4,  95,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2,  95,1,0,0,0,0, 0);
        add(3'b010,0,0, 0,0,4,  95,1,0,0,1,0, 0);
        add(3'b000,0,0, 0,0,2,  95,1,0,0,0,0, 0);
        add(3'b100,0,0, 0,0,4, 100,1,0,0,0,0, 0);
        add(3'b000,0,0, 0,0,2, 100,1,0,0,0,0, 0);
        // price 0: full credit returned as change
        add(3'b000,1,0, 0,0,1,   0,2,1,0,0,0, 0);
        add(3'b000,0,0, 0,0,1,   0,3,0,0,0,1,100);
        add(3'b000,0,0, 0,1,1,   0,0,0,0,0,0, 0);
        // Two coins rise together: only coin 0 credited, one reject pulse
        add(3'b011,0,0, 0,0,4,  25,1,0,0,1,0, 0);
        add(3'b000,0,0, 0,0,2,  25,1,0,0,0,0, 0);
        // Exact price: no change, DISPENSE goes straight to IDLE; held vend_req/cancel ignored in IDLE
        add(3'b000,1,0,25,0,1,   0,2,1,0,0,0, 0);
        add(3'b000,1,0,25,0,1,   0,0,0,0,0,0, 0);
        add(3'b000,1,0,25,0,2,   0,0,0,0,0,0, 0);
        add(3'b000,0,1,25,0,1,   0,0,0,0,0,0, 0);

        // Reset state
        tick(2);
        chk("reset_credit", credit, 0);
        chk("reset_state", state, 0);
        chk("reset_cv", change_valid, 0);
        chk("reset_amt", change_amt, 0);
        chk("reset_pulses", {vend, insufficient, coin_reject}, 0);
        rst_n = 1'b1;
        tick(1);

        // Bounce: single-cycle high never qualifies
        coin_raw = 3'b100;
        tick(1);
        coin_raw = 3'b000;
        tick(4);
        chk("bounce_credit", credit, 0);
        chk("bounce_state", state, 0);

        // Latency: credit appears exactly DB_STAGES edges after first sample
        coin_raw = 3'b100;
        tick(3);
        chk("latency_early", credit, 0);
        tick(1);
        chk("latency_credit", credit, 5);
        chk("latency_state", state, 1);
        coin_raw = 3'b000;
        tick(3);
        chk("single_increment", credit, 5);

        // Async reset mid-ACCUM
        coin_raw = 3'b001;
        tick(4);
        chk("pre_reset_credit", credit, 30);
        coin_raw = 3'b000;
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_credit", credit, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_cv", change_valid, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        foreach (vecs[k]) begin
            coin_raw   = vecs[k].coin;
            vend_req   = vecs[k].vreq;
            cancel     = vecs[k].canc;
            price      = vecs[k].price;
            change_ack = vecs[k].ack;
            tick(vecs[k].n);
            checks++;
            if ({credit, state, vend, insufficient, coin_reject, change_valid, change_amt} !==
                {vecs[k].e_credit, vecs[k].e_state, vecs[k].e_vend, vecs[k].e_insuf,
                 vecs[k].e_rej, vecs[k].e_cv, vecs[k].e_amt}) begin
                errors++;
                $display("FAIL vec%0d: got cr=%0d st=%0d v=%0d i=%0d r=%0d cv=%0d amt=%0d expected cr=%0d st=%0d v=%0d i=%0d r=%0d cv=%0d amt=%0d",
                         k, credit, state, vend, insufficient, coin_reject, change_valid, change_amt,
                         vecs[k].e_credit, vecs[k].e_state, vecs[k].e_vend, vecs[k].e_insuf,
                         vecs[k].e_rej, vecs[k].e_cv, vecs[k].e_amt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
Parametrised coin-credit controller for the vending datapath. It debounces N coin inputs and accumulates their values into a saturation-checked credit register. On a purchase request it compares credit against a runtime price, pulses a vend strobe, and returns any change through a valid/ack handshake. Cancel refunds the full credit. It replaces fixed 4-state single-coin credit counting with value-weighted arithmetic.

Parameters:
NUM_COINS, 3, number of coin inputs (1..8)
CREDIT_W, 8, width of credit, price and change values
COIN_VALS, {8'd25, 8'd10, 8'd5}, packed NUM_COINS*CREDIT_W coin values; slice i = value of coin_raw[i]
MAX_CREDIT, 100, highest credit accepted; must fit in CREDIT_W bits
DB_STAGES, 3, shift-register length of the per-coin debouncer (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
coin_raw  input  NUM_COINS  raw coin sensors, level high while a coin passes
vend_req  input  1  level; purchase request, evaluated each cycle in ACCUM
cancel  input  1  level; refund request, has priority over vend_req
price  input  CREDIT_W  item price, sampled in the cycle vend_req is evaluated
change_ack  input  1  consumer accepts change_amt
credit  output  CREDIT_W  current accumulated credit
vend  output  1  one-cycle dispense strobe
insufficient  output  1  one-cycle pulse: vend_req with credit < price
coin_reject  output  1  one-cycle pulse: coin edge not accepted
change_valid  output  1  change_amt is valid, held until change_ack
change_amt  output  CREDIT_W  change to return; 0 when change_valid=0
state  output  2  FSM state encoding, for debug and status LEDs

Behaviour:
- Reset (async assert, sync release by clock): state=IDLE. credit, change_amt, all pulses, change_valid and debouncer registers are 0. Credit in progress is lost.
- Debounce per coin: shift in coin_raw[i] each clock. db_i = all DB_STAGES bits 1. edge_i = db_i & ~db_i_prev.
- Latency: coin_raw held high from edge k is visible in credit after edge k+DB_STAGES.
- Multiple edges in one cycle: lowest index is the candidate coin; every other edge raises coin_reject that cycle.
- FSM states: IDLE=0, ACCUM=1, DISPENSE=2, REFUND=3.
- IDLE:
  - Accepted coin: credit <= val, go to ACCUM.
  - vend_req/cancel ignored.
- ACCUM:
  - cancel: change_amt <= credit, credit <= 0, go to REFUND.
  - Otherwise vend_req with credit >= price: change_amt <= credit-price, credit <= 0, go to DISPENSE.
  - Otherwise vend_req with credit < price: insufficient pulses, stay in ACCUM.
  - Otherwise, coin accepted: credit <= credit+val.
  - A coin edge in the same cycle as cancel or vend_req is rejected (coin_reject). Price is compared against pre-coin credit.
- Coin acceptance rule (IDLE/ACCUM): compute credit+val in CREDIT_W+1 bits. If > MAX_CREDIT, coin_reject pulses and credit is unchanged. Never wraps.
- DISPENSE (exactly 1 cycle): vend=1. Next state is REFUND if change_amt != 0, else IDLE.
- REFUND: change_valid=1 and change_amt stable until change_ack is sampled high. Then change_valid <= 0, change_amt <= 0, go to IDLE. change_ack outside REFUND is ignored.
- DISPENSE/REFUND: all coin edges are rejected (coin_reject).
- Cycle-level pulse rules:
  - vend, insufficient and coin_reject are registered and last exactly one cycle.
  - vend_req held high re-evaluates every cycle in ACCUM, so insufficient may repeat.
  - After DISPENSE, vend_req held high triggers nothing until credit is nonzero again (the FSM is in IDLE).
- price=0 with credit>0: vend succeeds and full credit is returned as change.

Decomposition:
- Package vend_pkg: state enum type vend_state_e (IDLE/ACCUM/DISPENSE/REFUND, 2-bit) and default coin value constants.
- Sub-module coin_debounce (parameters DB_STAGES): one raw input, outputs db level and rising-edge pulse; instantiated NUM_COINS times via generate.

Test Plan:
- Reset mid-ACCUM: insert 25 (credit=25), assert rst_n=0 -> credit=0, state=IDLE, change_valid=0 immediately (async).
- Coin 2 (value 5) high for 1 cycle only (bounce) -> no credit change. Held 4 cycles -> credit=5 exactly DB_STAGES edges after the first sampled high, single increment.
- Insert 25,25,10 (credit=60), price=50, vend_req=1 -> vend pulses 1 cycle. Then change_valid=1, change_amt=10. change_ack after 5 cycles -> IDLE, change_amt=0.
- Credit=95, insert 10 -> coin_reject pulse, credit stays 95. Insert 5 -> credit=100.
- Credit=30, price=50, vend_req -> insufficient pulse, state ACCUM. Then cancel and vend_req together -> REFUND with change_amt=30, no vend.
- coin_raw[0] and coin_raw[1] rise on the same cycle -> credit += 25 only, coin_reject pulses once. Coin edge during REFUND -> coin_reject, credit stays 0.
